// File: rtl/adc_buffer_streamer_if.sv
// Sample stream between adc_buffer_streamer and its consumer (DMA, UART or processing block).
// A transfer happens on a clock edge where m_valid && m_ready. Once m_valid is high, m_data/m_first/m_last hold until that transfer.
interface adc_buffer_streamer_if #(
  parameter int DATA_WIDTH = 12
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_first;
  logic                  m_last;

  modport master (output m_data, output m_valid, output m_first, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_first, input m_last, output m_ready);
endinterface

// File: rtl/adc_buffer_streamer.sv
// Streams a captured frame out of the sample buffer, addresses 0..2^ADDR_WIDTH-1, as a valid/ready stream.
// A 2-entry FIFO absorbs the buffer's 1-cycle read latency and downstream backpressure.
module adc_buffer_streamer #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  adc_clock,
  input  logic                  reset,
  input  logic                  capture_done,
  input  logic                  start_readout,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  adc_buffer_streamer_if.master m,
  output logic                  busy,
  output logic                  readout_done,
  output logic [15:0]           frame_count,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
  logic                  inflight_q, inflight_d;
  logic                  tag_first_q, tag_first_d;
  logic                  tag_last_q, tag_last_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_d [2];
  logic                  fifo_first_q [2];
  logic                  fifo_first_d [2];
  logic                  fifo_last_q [2];
  logic                  fifo_last_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  readout_done_q, readout_done_d;
  logic [15:0]           frame_count_q, frame_count_d;

  logic       push, pop, flush, issue;
  logic [2:0] level;

  always_comb begin
    push  = inflight_q;
    pop   = (count_q != 2'd0) && m.m_ready;
    flush = abort && (state_q != ST_IDLE);
    // Occupancy the FIFO will have once the in-flight read lands and this cycle's pop is taken.
    level = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    issue = (state_q == ST_STREAM) && !abort && (level < 3'd2);

    state_d        = state_q;
    read_addr_d    = read_addr_q;
    inflight_d     = issue;
    tag_first_d    = tag_first_q;
    tag_last_d     = tag_last_q;
    fifo_data_d    = fifo_data_q;
    fifo_first_d   = fifo_first_q;
    fifo_last_d    = fifo_last_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q + {1'b0, push} - {1'b0, pop};
    readout_done_d = 1'b0;
    frame_count_d  = frame_count_q;

    if (push) begin
      fifo_data_d[wr_ptr_q]  = read_data;
      fifo_first_d[wr_ptr_q] = tag_first_q;
      fifo_last_d[wr_ptr_q]  = tag_last_q;
      wr_ptr_d               = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // Markers travel with the read as an address tag, so they survive any backpressure.
    if (issue) begin
      tag_first_d = (read_addr_q == '0);
      tag_last_d  = (read_addr_q == LAST_ADDR);
    end

    case (state_q)
      ST_IDLE: begin
        if (start_readout && capture_done) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (issue) begin
          if (read_addr_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else begin
            read_addr_d = read_addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!abort && (count_q == 2'd0) && !inflight_q) begin
          state_d        = ST_IDLE;
          read_addr_d    = '0;
          readout_done_d = 1'b1;
          frame_count_d  = frame_count_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d     = ST_IDLE;
      read_addr_d = '0;
      inflight_d  = 1'b0;
      count_d     = 2'd0;
      wr_ptr_d    = 1'b0;
      rd_ptr_d    = 1'b0;
    end
  end

  always_ff @(posedge adc_clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      read_addr_q    <= '0;
      inflight_q     <= 1'b0;
      tag_first_q    <= 1'b0;
      tag_last_q     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i]  <= '0;
        fifo_first_q[i] <= 1'b0;
        fifo_last_q[i]  <= 1'b0;
      end
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      readout_done_q <= 1'b0;
      frame_count_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      read_addr_q    <= read_addr_d;
      inflight_q     <= inflight_d;
      tag_first_q    <= tag_first_d;
      tag_last_q     <= tag_last_d;
      fifo_data_q    <= fifo_data_d;
      fifo_first_q   <= fifo_first_d;
      fifo_last_q    <= fifo_last_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      readout_done_q <= readout_done_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign read_addr    = read_addr_q;
  assign m.m_valid    = (count_q != 2'd0);
  assign m.m_data     = fifo_data_q[rd_ptr_q];
  assign m.m_first    = fifo_first_q[rd_ptr_q];
  assign m.m_last     = fifo_last_q[rd_ptr_q];
  assign busy         = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign readout_done = readout_done_q;
  assign frame_count  = frame_count_q;
  assign state_dbg    = state_q;

  fifo_no_overflow: assert property (@(posedge adc_clock) disable iff (reset)
    !(push && !pop && !flush && (count_q == 2'd2)));

endmodule

// File: tb/tb_adc_buffer_streamer.sv
// Bench for adc_buffer_streamer: buffer model preloaded with data = address, startup vector table,
// then abort, reset, back-to-back and random-backpressure frames checked by an in-order scoreboard.
module tb_adc_buffer_streamer;
  localparam int DW = 12;
  localparam int AW = 12;
  localparam int N  = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          capture_done = 1'b0;
  logic          start_readout = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data = '0;
  logic          busy, readout_done;
  logic [15:0]   frame_count;
  logic [1:0]    state_dbg;

  adc_buffer_streamer_if #(.DATA_WIDTH(DW)) s_if ();

  adc_buffer_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .adc_clock    (clk),
    .reset        (rst),
    .capture_done (capture_done),
    .start_readout(start_readout),
    .abort        (abort),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .m            (s_if),
    .busy         (busy),
    .readout_done (readout_done),
    .frame_count  (frame_count),
    .state_dbg    (state_dbg)
  );

  // clock / reset / buffer model
  always #5 clk = ~clk;

  logic [DW-1:0] mem [N];
  initial for (int i = 0; i < N; i++) mem[i] = i[DW-1:0];
  always @(posedge clk) read_data <= mem[read_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int xfer_total = 0;
  int done_total = 0;
  int first_xfer_cyc = 0;
  int last_xfer_cyc = 0;
  int exp_frames = 0;
  logic hold_pend = 1'b0;
  logic [DW+1:0] held = '0;
  logic [DW-1:0] e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor at negedge: inputs were driven just after posedge, so valid&&ready here is the transfer at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 32'(s_if.m_valid), 32'd1);
        chk("hold_stable", 32'({s_if.m_first, s_if.m_last, s_if.m_data}), 32'(held));
      end
      hold_pend = 1'b0;
      if (readout_done) done_total++;
      if (s_if.m_valid && s_if.m_ready) begin
        xfer_total++;
        last_xfer_cyc = cyc + 1;
        chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_data", 32'(s_if.m_data), 32'(e));
          chk("sb_first", 32'(s_if.m_first), 32'(e == '0));
          chk("sb_last", 32'(s_if.m_last), 32'(e == DW'(N - 1)));
          if (e == '0) first_xfer_cyc = cyc + 1;
        end
      end else if (s_if.m_valid && !abort) begin
        hold_pend = 1'b1;
        held = {s_if.m_first, s_if.m_last, s_if.m_data};
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input int duty);
    s_if.m_ready = ($urandom_range(0, 99) < duty);
  endtask

  task automatic push_frames(input int nframes);
    for (int k = 0; k < nframes; k++)
      for (int i = 0; i < N; i++) exp_q.push_back(i[DW-1:0]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_m_valid"}, 32'(s_if.m_valid), 32'd0);
    chk({tag, "_m_data"}, 32'(s_if.m_data), 32'd0);
    chk({tag, "_m_first"}, 32'(s_if.m_first), 32'd0);
    chk({tag, "_m_last"}, 32'(s_if.m_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_read_addr"}, 32'(read_addr), 32'd0);
    chk({tag, "_done"}, 32'(readout_done), 32'd0);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    chk({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  task automatic run_to_done(input int duty, input string tag, input bit keep_start);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      set_ready(duty);
      tick();
      if (readout_done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      exp_frames++;
      chk({tag, "_frame_count"}, 32'(frame_count), 32'(exp_frames % 65536));
      chk({tag, "_done_lag"}, 32'(cyc - last_xfer_cyc), 32'd1);
      chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
      chk({tag, "_addr_idle"}, 32'(read_addr), 32'd0);
    end
    if (!keep_start) start_readout = 1'b0;
    set_ready(duty);
    tick();
    chk({tag, "_done_pulse"}, 32'(readout_done), 32'd0);
  endtask

  typedef struct {
    logic          start;
    logic          ready;
    logic          exp_valid;
    logic          exp_busy;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_first;
  } vec_t;

  vec_t tbl [8];
  int   base_x, base_d;

  initial begin
    // start accepted at step 0; m_valid two edges later; steps 4-5 stall with a full FIFO
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 12'd0, 12'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 12'd1, 12'd0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 12'd2, 12'd0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 12'd3, 12'd1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'd3, 12'd1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'd3, 12'd1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 12'd4, 12'd2, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 12'd5, 12'd3, 1'b0};

    s_if.m_ready = 1'b0;
    #2;
    check_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // start without capture_done is ignored
    capture_done = 1'b0;
    start_readout = 1'b1;
    repeat (4) tick();
    chk("nocap_busy", 32'(busy), 32'd0);
    chk("nocap_addr", 32'(read_addr), 32'd0);
    chk("nocap_valid", 32'(s_if.m_valid), 32'd0);
    chk("nocap_state", 32'(state_dbg), 32'd0);
    start_readout = 1'b0;
    capture_done = 1'b1;
    tick();

    // startup latency and backpressure table, then finish frame
    push_frames(1);
    for (int i = 0; i < 8; i++) begin
      start_readout = tbl[i].start;
      s_if.m_ready = tbl[i].ready;
      tick();
      chk($sformatf("tbl%0d_valid", i), 32'(s_if.m_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_addr", i), 32'(read_addr), 32'(tbl[i].exp_addr));
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_data", i), 32'(s_if.m_data), 32'(tbl[i].exp_data));
        chk($sformatf("tbl%0d_first", i), 32'(s_if.m_first), 32'(tbl[i].exp_first));
      end
    end
    run_to_done(100, "A", 1'b0);

    // abort after 100 transfers
    push_frames(1);
    base_x = xfer_total;
    start_readout = 1'b1;
    s_if.m_ready = 1'b1;
    tick();
    start_readout = 1'b0;
    for (int i = 0; i < 400 && (xfer_total - base_x) < 100; i++) tick();
    chk("abort_reach100", 32'(xfer_total - base_x), 32'd100);
    base_d = done_total;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(s_if.m_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr", 32'(read_addr), 32'd0);
    exp_q.delete();
    repeat (5) tick();
    chk("abort_no_done", 32'(done_total - base_d), 32'd0);
    chk("abort_frame_count", 32'(frame_count), 32'(exp_frames));
    chk("abort_valid_stays", 32'(s_if.m_valid), 32'd0);

    // restart from address 0 at full throughput
    push_frames(1);
    start_readout = 1'b1;
    tick();
    start_readout = 1'b0;
    run_to_done(100, "B", 1'b0);
    chk("B_throughput", 32'(last_xfer_cyc - first_xfer_cyc), 32'(N - 1));

    // asynchronous reset mid-stream with the FIFO stalled full
    push_frames(1);
    start_readout = 1'b1;
    s_if.m_ready = 1'b1;
    tick();
    start_readout = 1'b0;
    repeat (50) tick();
    s_if.m_ready = 1'b0;
    repeat (5) tick();
    chk("pre_rst_valid", 32'(s_if.m_valid), 32'd1);
    chk("pre_rst_frames", 32'(frame_count), 32'd2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    exp_q.delete();
    exp_frames = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // three back-to-back frames with start held
    push_frames(3);
    base_d = done_total;
    start_readout = 1'b1;
    run_to_done(100, "G1", 1'b1);
    run_to_done(100, "G2", 1'b1);
    run_to_done(100, "G3", 1'b0);
    chk("G_done_pulses", 32'(done_total - base_d), 32'd3);
    chk("G_frame_count", 32'(frame_count), 32'd3);

    // random 30% backpressure
    push_frames(1);
    start_readout = 1'b1;
    tick();
    start_readout = 1'b0;
    run_to_done(30, "C", 1'b0);

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_buffer_streamer.md
Name: adc_buffer_streamer

Overview:
- Downstream consumer of the ADC capture stage.
- Once a capture completes, it walks the 4096-entry sample buffer through the buffer's read port, address 0 to 4095.
- It emits the samples as a valid/ready stream with first/last frame markers, for a DMA, UART or processing block.
- It absorbs the buffer's 1-cycle read latency and downstream backpressure with an internal 2-entry FIFO.

Parameters:
DATA_WIDTH, 12, sample width; must match the capture stage and buffer.
ADDR_WIDTH, 12, buffer address width; the frame length is 2^ADDR_WIDTH samples.

Ports:
adc_clock  input  1  single clock, same domain as the capture stage and buffer.
reset  input  1  asynchronous, active-high reset.
capture_done  input  1  level from the capture stage; the buffer holds a complete frame.
start_readout  input  1  request to stream the buffer; sampled only in IDLE.
abort  input  1  terminates an ongoing readout.
read_addr  output  ADDR_WIDTH  buffer read address (registered).
read_data  input  DATA_WIDTH  buffer output; valid exactly 1 cycle after read_addr changes.
m_data  output  DATA_WIDTH  stream sample.
m_valid  output  1  m_data, m_first and m_last are valid.
m_ready  input  1  downstream accepts; a transfer occurs when m_valid && m_ready.
m_first  output  1  high with the sample from address 0.
m_last  output  1  high with the sample from address 2^ADDR_WIDTH-1.
busy  output  1  high in the STREAM and DRAIN states.
readout_done  output  1  1-cycle pulse after the last sample is transferred.
frame_count  output  16  number of completed (non-aborted) readouts; wraps at 65535 to 0.

Behaviour:
- Reset values: every output is 0, FIFO empty, state IDLE. Reset mid-readout discards everything immediately; no readout_done pulse.
- States:
  - IDLE -> STREAM when start_readout && capture_done are both high at an edge. start_readout without capture_done is ignored.
  - STREAM: issues reads. After the read of the last address is issued, -> DRAIN.
  - DRAIN: waits until the FIFO is empty and no read is in flight, then -> IDLE and pulses readout_done in the same cycle. frame_count increments on that same edge.
  - abort in STREAM or DRAIN: -> IDLE next edge, FIFO flushed, in-flight data dropped, m_valid low after that edge, no readout_done, frame_count unchanged. abort in IDLE is ignored.
- Read issue:
  - A read is issued in STREAM when (fifo_count + inflight - pop) < 2, where pop = m_valid && m_ready.
  - read_addr increments by 1 per issued read and never wraps within a frame.
  - read_addr returns to 0 on entering IDLE.
- Latency:
  - The edge that accepts start drives read_addr=0.
  - m_valid first rises 2 edges after the accepting edge.
- Throughput: with m_ready held high, one sample is transferred every cycle, and all 4096 samples complete in 4096 consecutive cycles after the first.
- Handshake:
  - Once m_valid is high, m_data, m_first and m_last are held stable until the transfer occurs.
  - m_valid does not drop without a transfer, except on abort or reset.
- No sample is ever dropped or duplicated under arbitrary m_ready patterns. The FIFO never overflows; an overflow is an assertion failure.
- m_first and m_last are derived from the stored address tag, not from read_addr. For ADDR_WIDTH=1 (2 samples), each marker is on its own sample.
- The buffer contents are not modified, so a repeat start_readout after done re-streams the identical frame.
- capture_done falling during a readout has no effect.
- A start_readout held high continuously re-triggers on each return to IDLE while capture_done is high.

Test Plan:
- Buffer preloaded with data = address[11:0]; start_readout pulse, m_ready=1 -> m_valid rises 2 cycles after start; 4096 consecutive transfers with values 0..4095; m_first only on 0, m_last only on 4095; readout_done 1 cycle after the last transfer; frame_count=1.
- Same preload, m_ready random 30% duty -> received sequence exactly 0..4095, no gaps or repeats; m_data stable while m_valid && !m_ready.
- start_readout with capture_done=0 -> stays IDLE; busy=0, read_addr=0, m_valid=0.
- abort asserted after 100 transfers -> m_valid=0 next cycle, busy=0, no readout_done, frame_count unchanged; a new start streams from address 0 again.
- reset asserted mid-stream while m_ready=0 -> all outputs 0 immediately (asynchronous); subsequent full readout correct.
- Three back-to-back readouts with start_readout held high -> frame_count=3, each frame 0..4095, one readout_done pulse per frame.
